io_output_ctrl: RTL and testbench

Parametrised memory-mapped output register bank: the next generation of the LED/HEX/LCD output buffer. It holds NUM_CH output channels of DATA_W bits each. Writes support byte masks and write/set/clear/toggle modes. A per-channel blink mask and a global PWM brightness control gate the driven outputs. It sits between the LSU store path and board-level output pins; raw register contents can be read back for load instructions.

---
 rtl/io_output_ctrl.sv | 133 +++++++++++++
 tb/tb_io_output_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/io_output_ctrl.sv
// Memory-mapped output register bank: NUM_CH masked-write channels with
// per-channel blink masks and a global PWM brightness gate on the driven outputs.
module io_output_ctrl #(
  parameter int NUM_CH    = 5,
  parameter int DATA_W    = 32,
  parameter int PWM_W     = 8,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                                        i_clk,
  input  logic                                        i_reset,
  input  logic [NUM_CH-1:0]                           i_wren,
  input  logic [NUM_CH-1:0]                           i_blink_wren,
  input  logic [1:0]                                  i_mode,
  input  logic [DATA_W/8-1:0]                         i_bmask,
  input  logic [DATA_W-1:0]                           i_wdata,
  input  logic                                        i_duty_wren,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] i_rsel,
  output logic [DATA_W-1:0]                           o_rdata,
  output logic [NUM_CH*DATA_W-1:0]                    o_ch,
  output logic                                        o_blink_phase
);

  localparam int NB     = DATA_W / 8;
  localparam int RSEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W  = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_DIV - 1);

  logic [DATA_W-1:0] data_q  [NUM_CH];
  logic [DATA_W-1:0] data_d  [NUM_CH];
  logic [DATA_W-1:0] blink_q [NUM_CH];
  logic [DATA_W-1:0] blink_d [NUM_CH];
  logic [PWM_W-1:0]  duty_q, duty_d;
  logic [PWM_W-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic [CNT_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic              phase_q, phase_d;
  logic [DATA_W-1:0] lane_mask;
  logic [DATA_W-1:0] wdata_masked;
  logic              blink_wrap;
  logic              pwm_on;

  // Masked data d already has disabled lanes zeroed, so set/clear/toggle
  // leave those lanes alone without needing the mask again.
  function automatic logic [DATA_W-1:0] f_apply_mode(
    input logic [DATA_W-1:0] cur,
    input logic [1:0]        mode,
    input logic [DATA_W-1:0] m,
    input logic [DATA_W-1:0] d
  );
    logic [DATA_W-1:0] res;
    case (mode)
      2'b00:   res = (cur & ~m) | d;
      2'b01:   res = cur | d;
      2'b10:   res = cur & ~d;
      default: res = cur ^ d;
    endcase
    return res;
  endfunction

  always_comb begin
    lane_mask = '0;
    for (int b = 0; b < NB; b++) begin
      lane_mask[b*8 +: 8] = {8{i_bmask[b]}};
    end
    wdata_masked = i_wdata & lane_mask;
  end

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      data_d[k]  = data_q[k];
      blink_d[k] = blink_q[k];
      if (i_wren[k]) begin
        data_d[k] = f_apply_mode(data_q[k], i_mode, lane_mask, wdata_masked);
      end
      if (i_blink_wren[k]) begin
        blink_d[k] = (blink_q[k] & ~lane_mask) | wdata_masked;
      end
    end
    duty_d = i_duty_wren ? i_wdata[PWM_W-1:0] : duty_q;
  end

  // Free-running timers; register writes never disturb them.
  always_comb begin
    blink_wrap  = (blink_cnt_q == BLINK_LAST);
    blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + 1'b1;
    phase_d     = phase_q ^ blink_wrap;
    pwm_cnt_d   = pwm_cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        data_q[k]  <= '0;
        blink_q[k] <= '0;
      end
      duty_q      <= '1;
      pwm_cnt_q   <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        data_q[k]  <= data_d[k];
        blink_q[k] <= blink_d[k];
      end
      duty_q      <= duty_d;
      pwm_cnt_q   <= pwm_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  // Outputs depend on flops only (plus i_rsel for the readback mux).
  always_comb begin
    pwm_on = (&duty_q) | (pwm_cnt_q < duty_q);
    o_ch   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      o_ch[k*DATA_W +: DATA_W] = data_q[k]
                               & ~(blink_q[k] & {DATA_W{~phase_q}})
                               & {DATA_W{pwm_on}};
    end
  end

  always_comb begin
    o_rdata = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (i_rsel == RSEL_W'(k)) begin
        o_rdata = data_q[k];
      end
    end
  end

  assign o_blink_phase = phase_q;

endmodule

// File: tb/tb_io_output_ctrl.sv
// Scoreboard bench for io_output_ctrl: a behavioural model predicts each
// post-edge output set, which is queued at drive time and compared after the edge.
module tb_io_output_ctrl;

  localparam int NUM_CH    = 5;
  localparam int DATA_W    = 32;
  localparam int PWM_W     = 8;
  localparam int BLINK_DIV = 4;

  logic                       clk;
  logic                       rst_n;
  logic [NUM_CH-1:0]          wren, blink_wren;
  logic [1:0]                 mode;
  logic [3:0]                 bmask;
  logic [DATA_W-1:0]          wdata;
  logic                       duty_wren;
  logic [2:0]                 rsel;
  logic [DATA_W-1:0]          rdata;
  logic [NUM_CH*DATA_W-1:0]   och;
  logic                       phase;

  io_output_ctrl #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .PWM_W(PWM_W), .BLINK_DIV(BLINK_DIV)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .i_wren(wren), .i_blink_wren(blink_wren),
    .i_mode(mode), .i_bmask(bmask), .i_wdata(wdata), .i_duty_wren(duty_wren),
    .i_rsel(rsel), .o_rdata(rdata), .o_ch(och), .o_blink_phase(phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_CH*DATA_W-1:0] ch;
    logic [DATA_W-1:0]        rd;
    logic                     ph;
  } exp_t;

  exp_t q[$];

  logic [DATA_W-1:0] m_data  [NUM_CH];
  logic [DATA_W-1:0] m_blink [NUM_CH];
  logic [PWM_W-1:0]  m_duty;
  logic [PWM_W-1:0]  m_pc;
  int                m_bc;
  logic              m_ph;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) begin
      m_data[k]  = '0;
      m_blink[k] = '0;
    end
    m_duty = '1;
    m_pc   = '0;
    m_bc   = 0;
    m_ph   = 1'b1;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    logic on;
    on   = (m_duty == 8'hFF) || (m_pc < m_duty);
    e.ch = '0;
    e.rd = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (on) e.ch[k*DATA_W +: DATA_W] = m_data[k] & ~(m_ph ? 32'h0 : m_blink[k]);
      if (int'(rsel) == k) e.rd = m_data[k];
    end
    e.ph = m_ph;
    return e;
  endfunction

  // Called at a falling edge with inputs already driven; consumes one rising edge.
  task automatic step();
    exp_t e;
    logic [DATA_W-1:0] m, d;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = bmask[b] ? 8'hFF : 8'h00;
    d = wdata & m;
    for (int k = 0; k < NUM_CH; k++) begin
      if (wren[k]) begin
        case (mode)
          2'b00: m_data[k] = (m_data[k] & ~m) | d;
          2'b01: m_data[k] = m_data[k] | d;
          2'b10: m_data[k] = m_data[k] & ~d;
          default: m_data[k] = m_data[k] ^ d;
        endcase
      end
      if (blink_wren[k]) m_blink[k] = (m_blink[k] & ~m) | d;
    end
    if (duty_wren) m_duty = wdata[PWM_W-1:0];
    if (m_bc == BLINK_DIV - 1) begin
      m_bc = 0;
      m_ph = ~m_ph;
    end else begin
      m_bc++;
    end
    m_pc = m_pc + 1'b1;
    q.push_back(model_out());
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("o_ch", och, e.ch);
    chk("o_rdata", rdata, e.rd);
    chk("phase", phase, e.ph);
    @(negedge clk);
    wren       = '0;
    blink_wren = '0;
    duty_wren  = 1'b0;
  endtask

  task automatic wr(input logic [4:0] ch, input logic [1:0] md, input logic [3:0] bm,
                    input logic [31:0] dat);
    wren  = ch;
    mode  = md;
    bmask = bm;
    wdata = dat;
    step();
  endtask

  task automatic set_duty(input logic [7:0] dv);
    duty_wren = 1'b1;
    wdata     = {24'h0, dv};
    bmask     = 4'h0;
    step();
  endtask

  task automatic count_on(input string tag, input int exp_on);
    int on_cnt;
    on_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      if (och[31:0] == 32'hFFFFFFFF) on_cnt++;
    end
    chk(tag, on_cnt, exp_on);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wren = '0; blink_wren = '0; mode = 2'b00; bmask = 4'h0; wdata = '0;
    duty_wren = 1'b0; rsel = 3'd0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_och", och, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_phase", phase, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: full write on ch0
    wr(5'b00001, 2'b00, 4'hF, 32'hDEADBEEF);
    chk("t1_rdata", rdata, 32'hDEADBEEF);
    chk("t1_och", och, {128'h0, 32'hDEADBEEF});

    // 2: byte masks and modes on ch1
    rsel = 3'd1;
    wr(5'b00010, 2'b00, 4'hF, 32'h12345678);
    wr(5'b00010, 2'b00, 4'h5, 32'hAABBCCDD);
    chk("t2_wr", rdata, 32'h12BB56DD);
    wr(5'b00010, 2'b01, 4'hF, 32'h000000F0);
    chk("t2_set", rdata, 32'h12BB56FD);
    wr(5'b00010, 2'b10, 4'hF, 32'h12000000);
    chk("t2_clr", rdata, 32'h00BB56FD);
    wr(5'b00010, 2'b11, 4'h1, 32'hFFFFFFFF);
    chk("t2_tog", rdata, 32'h00BB5602);
    wr(5'b00010, 2'b00, 4'h0, 32'hFFFFFFFF);
    chk("t2_nomask", rdata, 32'h00BB5602);
    rsel = 3'd6;
    step();
    chk("t2_oor", rdata, 32'h0);

    // 3: blink on ch2
    rsel = 3'd2;
    wr(5'b00100, 2'b00, 4'hF, 32'h0000FFFF);
    blink_wren = 5'b00100;
    wr(5'b00000, 2'b00, 4'hF, 32'h000000FF);
    for (int i = 0; i < 12; i++) step();

    // 4: PWM brightness on ch0
    wr(5'b00001, 2'b00, 4'hF, 32'hFFFFFFFF);
    set_duty(8'd64);
    count_on("t4_duty64", 64);
    set_duty(8'd0);
    count_on("t4_duty0", 0);
    set_duty(8'hFF);
    count_on("t4_dutyFF", 256);

    // 5: multi-hot write plus blink write on the same channel
    rsel = 3'd4;
    blink_wren = 5'b00100;
    wr(5'b10101, 2'b00, 4'hF, 32'h0F0F0F0F);
    chk("t5_ch4", rdata, 32'h0F0F0F0F);
    chk("t5_ch1", och[63:32], 32'h00BB5602);
    for (int i = 0; i < 8; i++) step();

    // 6: asynchronous reset mid-operation
    set_duty(8'd10);
    wr(5'b01000, 2'b00, 4'hF, 32'hCAFEBABE);
    for (int i = 0; i < 5; i++) step();
    rsel  = 3'd3;
    wren  = 5'b01000;
    mode  = 2'b00;
    bmask = 4'hF;
    wdata = 32'h11111111;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_och", och, 0);
    chk("t6_phase", phase, 1);
    chk("t6_rdata", rdata, 0);
    @(posedge clk);
    #1;
    chk("t6_lostwr", rdata, 0);
    @(negedge clk);
    wren = '0;
    model_reset();
    rst_n = 1'b1;
    wr(5'b01000, 2'b00, 4'hF, 32'hCAFEBABE);
    for (int i = 0; i < 10; i++) step();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
